fft_bin_collector: RTL and testbench

- Sink-side consumer of the streaming 16-point DIT FFT output (out_x / out_nd / overflow).
- Captures each frame of N consecutive bins into a ping-pong buffer and tracks the peak-magnitude bin during capture.
- Publishes complete frames to downstream logic (classifier / host readout) through a random-access read port with a ready/ack handshake.

---
 rtl/fft_bin_collector.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fft_bin_collector.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bin_collector.sv
`default_nettype none
// ============================================================================
// Module   : fft_bin_collector
// Purpose  : Sink for the streaming 16-point FFT output. Each frame of N
//            consecutive bins is captured into one half of a ping-pong
//            buffer. The peak-magnitude bin is tracked while the frame is
//            captured. Complete frames are handed to downstream logic, which
//            reads the bins through a registered random-access port and
//            releases the bank with frame_ack.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_x         bin value (signed, bit 0 = MSB, as on the FFT bus)
//   in_nd        bin strobe, high for N consecutive cycles per frame
//   in_ovf       FFT overflow flag, qualified by in_nd
//   frame_ready  a complete frame is held in the read bank
//   frame_ack    downstream releases the read bank (used only when ready)
//   rd_en        read strobe
//   rd_addr      bin index to read
//   rd_data      registered read data (bit 0 = MSB)
//   rd_valid     rd_data valid, one cycle after rd_en
//   peak_bin     index of the largest |bin| in the read-bank frame
//   peak_mag     |bin| at peak_bin, unsigned
//   overrun      sticky: a frame was dropped because the read bank was busy
//   frame_err    sticky: short frame, or in_ovf during capture
//   clr_err      synchronous clear of overrun and frame_err
// ============================================================================
module fft_bin_collector #(
  parameter int WIDTH = 24,
  parameter int N     = 16,
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [0:WIDTH-1] in_x,
  input  logic             in_nd,
  input  logic             in_ovf,
  output logic             frame_ready,
  input  logic             frame_ack,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [0:WIDTH-1] rd_data,
  output logic             rd_valid,
  output logic [LOG2N-1:0] peak_bin,
  output logic [WIDTH-1:0] peak_mag,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [WIDTH-1:0] MAG_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] VAL_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state;
  state_t             state_nxt;
  logic [LOG2N-1:0]   cnt;
  logic [LOG2N-1:0]   cnt_nxt;

  logic               wr_bank;     // bank currently being filled
  logic               rd_bank;     // bank visible on the read port

  logic [WIDTH-1:0]   run_mag;     // running max of the frame being captured
  logic [LOG2N-1:0]   run_idx;

  logic [0:WIDTH-1]   mem [0:1][0:N-1];

  // --------------------------------------------------------------------------
  // Capture control decoded by the FSM
  // --------------------------------------------------------------------------
  logic               cap;         // a bin is written this cycle
  logic [LOG2N-1:0]   cap_idx;     // where it goes
  logic               first;       // it is bin 0 of a new frame
  logic               last;        // it is bin N-1, frame is complete
  logic               short_frame; // in_nd dropped before the frame completed

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cap         = 1'b0;
    cap_idx     = cnt;
    first       = 1'b0;
    last        = 1'b0;
    short_frame = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_nd) begin
          cap       = 1'b1;
          cap_idx   = '0;
          first     = 1'b1;
          cnt_nxt   = LOG2N'(1);
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (in_nd) begin
          cap = 1'b1;
          if (cnt == LAST_IDX) begin
            // Returning to IDLE lets a bin on the very next cycle open a
            // new frame, so back-to-back frames need no gap.
            last      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + LOG2N'(1);
          end
        end else begin
          short_frame = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Magnitude of the incoming bin. The most negative value has no positive
  // counterpart in WIDTH bits, so it saturates to the largest positive value.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] x_raw;
  logic [WIDTH-1:0] x_mag;

  assign x_raw = in_x;

  always_comb begin
    if (x_raw == VAL_MIN) begin
      x_mag = MAG_MAX;
    end else if (x_raw[WIDTH-1]) begin
      x_mag = ~x_raw + WIDTH'(1);
    end else begin
      x_mag = x_raw;
    end
  end

  // --------------------------------------------------------------------------
  // Peak candidate including the bin on the bus this cycle. Bin 0 always
  // replaces the stale max from the previous frame; later bins need to be
  // strictly larger, so the lowest index wins a tie. The commit path uses
  // this candidate directly so bin N-1 is counted.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] cand_mag;
  logic [LOG2N-1:0] cand_idx;

  always_comb begin
    cand_mag = run_mag;
    cand_idx = run_idx;
    if (cap && (first || (x_mag > run_mag))) begin
      cand_mag = x_mag;
      cand_idx = cap_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_mag <= '0;
      run_idx <= '0;
    end else if (cap) begin
      run_mag <= cand_mag;
      run_idx <= cand_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Commit. An ack on the same cycle frees the read bank before the new
  // frame looks at it, so the hand-over happens without a dropped frame.
  // --------------------------------------------------------------------------
  logic bank_free;
  logic commit_ok;
  logic commit_drop;
  logic err_set;

  assign bank_free   = ~frame_ready | frame_ack;
  assign commit_ok   = last & bank_free;
  assign commit_drop = last & ~bank_free;
  assign err_set     = short_frame | (cap & in_ovf);
  assign rd_bank     = ~wr_bank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank     <= 1'b0;
      frame_ready <= 1'b0;
      peak_bin    <= '0;
      peak_mag    <= '0;
    end else begin
      if (commit_ok) begin
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
        peak_bin    <= cand_idx;
        peak_mag    <= cand_mag;
      end else if (frame_ack) begin
        frame_ready <= 1'b0;
      end
    end
  end

  // Sticky flags: a new event on the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (commit_drop) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (err_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage. No reset: contents are only meaningful once a frame commits, and
  // a reset mid-frame simply leaves a partial frame that is never published.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[wr_bank][cap_idx] <= in_x;
    end
  end

  // Read port only ever addresses the read bank; the fill bank is private.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_bank][rd_addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_bin_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bin_collector
// Purpose  : Self-checking bench for fft_bin_collector. Read data is checked
//            through a queue of expected values pushed at rd_en time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bin_collector;

  localparam int WIDTH = 24;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [0:WIDTH-1] in_x = '0;
  logic             in_nd = 1'b0;
  logic             in_ovf = 1'b0;
  logic             frame_ready;
  logic             frame_ack = 1'b0;
  logic             rd_en = 1'b0;
  logic [LOG2N-1:0] rd_addr = '0;
  logic [0:WIDTH-1] rd_data;
  logic             rd_valid;
  logic [LOG2N-1:0] peak_bin;
  logic [WIDTH-1:0] peak_mag;
  logic             overrun;
  logic             frame_err;
  logic             clr_err = 1'b0;

  fft_bin_collector #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_x        (in_x),
    .in_nd       (in_nd),
    .in_ovf      (in_ovf),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .peak_bin    (peak_bin),
    .peak_mag    (peak_mag),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] exp_q[$];

  int fb[N];          // frame to send
  int mb[N];          // model of the committed read bank
  int m_pk_bin = 0;
  int m_pk_mag = 0;

  // --------------------------------------------------------------------------
  // Model helpers
  // --------------------------------------------------------------------------
  function automatic int mag_of(int v);
    if (v == -(1 << (WIDTH-1))) return (1 << (WIDTH-1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_commit();
    int best;
    int idx;
    best = -1;
    idx  = 0;
    for (int i = 0; i < N; i++) begin
      mb[i] = fb[i];
      if (mag_of(fb[i]) > best) begin
        best = mag_of(fb[i]);
        idx  = i;
      end
    end
    m_pk_bin = idx;
    m_pk_mag = best;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 ns after the rising edge; outputs are
  // sampled at that same point, i.e. away from the active edge.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_nd high after the last bin so a following call runs back to back.
  task automatic send_frame(input int len, input int ovf_at, input bit ack_last);
    for (int i = 0; i < len; i++) begin
      in_nd     = 1'b1;
      in_x      = WIDTH'(fb[i]);
      in_ovf    = (i == ovf_at);
      frame_ack = ack_last && (i == len - 1);
      tick();
    end
    in_ovf    = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    in_nd = 1'b0;
    repeat (n) tick();
  endtask

  task automatic read_check(input int addr, input logic [WIDTH-1:0] exp, input string name);
    int waited;
    logic [WIDTH-1:0] e;
    exp_q.push_back(exp);
    rd_en   = 1'b1;
    rd_addr = LOG2N'(addr);
    tick();
    rd_en  = 1'b0;
    waited = 0;
    while (rd_valid !== 1'b1 && waited < 4) begin
      tick();
      waited++;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (rd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: rd_valid=%b after %0d cycles, required 1", name, rd_valid, waited + 1);
    end else if (rd_data !== e) begin
      tests_failed++;
      $display("FAIL %s: rd_data=%h required %h", name, rd_data, e);
    end
  endtask

  task automatic do_ack(input string name);
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    tests_run++;
    if (frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: frame_ready=%b after ack, required 0", name, frame_ready);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({frame_ready, rd_valid, overrun, frame_err, peak_bin, peak_mag, rd_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready=%b valid=%b ovr=%b err=%b pbin=%0d pmag=%h rdata=%h, required all 0",
               frame_ready, rd_valid, overrun, frame_err, peak_bin, peak_mag, rd_data);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fb = '{0, 7, 70, 1, 100, 32, 70, 43, 0, 4, -70, -92, 87, -92, 64, -38};
    send_frame(N, -1, 1'b0);
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_ready: frame_ready=%b required 1", frame_ready);
    end
    idle(1);
    model_commit();
    tests_run++;
    if (peak_bin !== 4'd4 || peak_mag !== 24'd100) begin
      tests_failed++;
      $display("FAIL basic_peak: bin=%0d mag=%0d required bin=4 mag=100", peak_bin, peak_mag);
    end
    read_check(10, 24'hFFFFBA, "basic_rd10");
    read_check(4, WIDTH'(mb[4]), "basic_rd4");
    read_check(15, WIDTH'(mb[15]), "basic_rd15");
    tick();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 24'hFFFFDA) begin
      tests_failed++;
      $display("FAIL basic_hold: rd_valid=%b rd_data=%h required 0 / ffffda", rd_valid, rd_data);
    end
    do_ack("basic_ack");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < N; i++) fb[i] = 5;
    fb[3] = -(1 << (WIDTH-1));
    send_frame(N, -1, 1'b0);
    idle(1);
    tests_run++;
    if (peak_bin !== 4'd3 || peak_mag !== 24'h7FFFFF) begin
      tests_failed++;
      $display("FAIL sat_peak: bin=%0d mag=%h required bin=3 mag=7fffff", peak_bin, peak_mag);
    end
    read_check(3, 24'h800000, "sat_rd3");
    do_ack("sat_ack");

    for (int i = 0; i < N; i++) fb[i] = 0;
    fb[2] = 50;
    fb[9] = 50;
    send_frame(N, -1, 1'b0);
    idle(1);
    tests_run++;
    if (peak_bin !== 4'd2 || peak_mag !== 24'd50) begin
      tests_failed++;
      $display("FAIL tie_peak: bin=%0d mag=%0d required bin=2 mag=50", peak_bin, peak_mag);
    end
    do_ack("tie_ack");
  endtask

  task automatic test_back_to_back();
    int keep_mag;
    for (int i = 0; i < N; i++) fb[i] = 3 * i + 1;
    send_frame(N, -1, 1'b0);
    model_commit();
    keep_mag = m_pk_mag;
    for (int i = 0; i < N; i++) fb[i] = -(5 * i) - 2;
    send_frame(N, -1, 1'b0);
    idle(1);
    tests_run++;
    if (overrun !== 1'b1 || frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_overrun: overrun=%b ready=%b required 1/1", overrun, frame_ready);
    end
    tests_run++;
    if (peak_mag !== WIDTH'(keep_mag)) begin
      tests_failed++;
      $display("FAIL b2b_peak_kept: mag=%0d required %0d", peak_mag, keep_mag);
    end
    read_check(5, WIDTH'(mb[5]), "b2b_rd_first");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_clr: overrun=%b required 0", overrun);
    end
    do_ack("b2b_ack1");

    // Second frame's last bin coincides with the ack of the first.
    for (int i = 0; i < N; i++) fb[i] = 2 * i;
    send_frame(N, -1, 1'b0);
    for (int i = 0; i < N; i++) fb[i] = 100 - 6 * i;
    send_frame(N, -1, 1'b1);
    tests_run++;
    if (frame_ready !== 1'b1 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL ackcommit_flags: ready=%b overrun=%b required 1/0", frame_ready, overrun);
    end
    idle(1);
    model_commit();
    tests_run++;
    if (peak_bin !== LOG2N'(m_pk_bin) || peak_mag !== WIDTH'(m_pk_mag)) begin
      tests_failed++;
      $display("FAIL ackcommit_peak: bin=%0d mag=%0d required %0d/%0d", peak_bin, peak_mag, m_pk_bin, m_pk_mag);
    end
    read_check(7, WIDTH'(mb[7]), "ackcommit_rd7");
    do_ack("ackcommit_ack");
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < N; i++) fb[i] = 1000 + i;
    send_frame(9, -1, 1'b0);
    idle(1);
    tests_run++;
    if (frame_err !== 1'b1 || frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_err: frame_err=%b ready=%b required 1/0", frame_err, frame_ready);
    end
    for (int i = 0; i < N; i++) fb[i] = (i % 5) * -7;
    send_frame(N, -1, 1'b0);
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_next_ready: frame_ready=%b required 1", frame_ready);
    end
    idle(1);
    model_commit();
    tests_run++;
    if (peak_bin !== LOG2N'(m_pk_bin) || peak_mag !== WIDTH'(m_pk_mag)) begin
      tests_failed++;
      $display("FAIL short_next_peak: bin=%0d mag=%0d required %0d/%0d", peak_bin, peak_mag, m_pk_bin, m_pk_mag);
    end
    read_check(3, WIDTH'(mb[3]), "short_next_rd3");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_clr: frame_err=%b required 0", frame_err);
    end
    do_ack("short_ack");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) fb[i] = 11 * i - 60;
    send_frame(N, -1, 1'b0);
    idle(1);
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: frame_ready=%b required 1", frame_ready);
    end
    for (int i = 0; i < N; i++) fb[i] = 9999;
    send_frame(8, -1, 1'b0);
    #2;
    reset_n = 1'b0;
    in_nd   = 1'b0;
    #1;
    tests_run++;
    if ({frame_ready, rd_valid, overrun, frame_err, peak_bin, peak_mag, rd_data} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: ready=%b valid=%b ovr=%b err=%b pbin=%0d pmag=%h rdata=%h, required all 0",
               frame_ready, rd_valid, overrun, frame_err, peak_bin, peak_mag, rd_data);
    end
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) fb[i] = (i == 6) ? -77 : i;
    send_frame(N, -1, 1'b0);
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_next_ready: frame_ready=%b required 1", frame_ready);
    end
    idle(1);
    model_commit();
    tests_run++;
    if (peak_bin !== 4'd6 || peak_mag !== 24'd77) begin
      tests_failed++;
      $display("FAIL rstmid_next_peak: bin=%0d mag=%0d required 6/77", peak_bin, peak_mag);
    end
    read_check(0, WIDTH'(mb[0]), "rstmid_rd0");
    read_check(7, WIDTH'(mb[7]), "rstmid_rd7");
    do_ack("rstmid_ack");
  endtask

  task automatic test_ovf();
    for (int i = 0; i < N; i++) fb[i] = 300 - 17 * i;
    send_frame(N, 12, 1'b0);
    tests_run++;
    if (frame_ready !== 1'b1 || frame_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_flags: ready=%b frame_err=%b required 1/1", frame_ready, frame_err);
    end
    idle(1);
    model_commit();
    read_check(12, WIDTH'(mb[12]), "ovf_rd12");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tests_run++;
    if (frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clr: frame_err=%b required 0", frame_err);
    end
    do_ack("ovf_ack");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_short_frame();
    test_reset_mid();
    test_ovf();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
